// File: rtl/i2s_pkg.sv
// Shared I2S definitions for the synthesizer output path.
// Slot/position types and word-select encoding used by the transmitter.
package i2s_pkg;

    localparam int DATA_BIT    = 16;
    localparam int FRAME_SLOTS = 32;

    typedef logic [4:0] pos_t;

    typedef enum logic {
        CH_LEFT  = 1'b0,
        CH_RIGHT = 1'b1
    } ch_e;

    localparam pos_t POS_LAST = pos_t'(FRAME_SLOTS - 1);

    // Word select leads the data by one bit: it reflects the slot after p.
    function automatic ch_e lr_for_pos(input pos_t p);
        pos_t n;
        n = p + 5'd1;
        return n[4] ? CH_RIGHT : CH_LEFT;
    endfunction

endpackage

// File: rtl/i2s_tx_stream_sclk_gen.sv
// Clock-enable bit-clock divider with registered SCLK.
// Emits single-cycle strobes on the cycle SCLK is registered high/low.
module sclk_gen #(
    parameter int BCLK_DIV = 4
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic en,
    output logic sclk,
    output logic rise_tick,
    output logic fall_tick
);

    localparam int CW = $clog2(BCLK_DIV);
    localparam logic [CW-1:0] TERM = CW'(BCLK_DIV - 1);

    logic [CW-1:0] cnt;
    logic          term;

    assign term      = en && (cnt == TERM);
    assign rise_tick = term && !sclk;
    assign fall_tick = term && sclk;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cnt  <= '0;
            sclk <= 1'b0;
        end else if (!en) begin
            cnt  <= '0;
            sclk <= 1'b0;
        end else if (term) begin
            cnt  <= '0;
            sclk <= ~sclk;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/i2s_tx_stream.sv
// Mono I2S transmitter fed from a FWFT sample FIFO.
// Each popped sample is sent in both the left and right slots.
module i2s_tx_stream
    import i2s_pkg::*;
#(
    parameter int BCLK_DIV = 4
) (
    input  logic                i_clk,
    input  logic                i_reset_n,
    input  logic                i_en,
    input  logic                i_empty,
    input  logic [DATA_BIT-1:0] i_rd_data,
    output logic                o_rd_en,
    output logic                o_sclk,
    output logic                o_lrclk,
    output logic                o_sdata,
    output logic                o_underrun
);

    logic                  fall_tick;
    pos_t                  pos;
    logic [2*DATA_BIT-1:0] shift;
    logic [DATA_BIT-1:0]   sample;
    logic                  lrclk;
    logic                  rd_en;
    logic                  underrun;

    sclk_gen #(
        .BCLK_DIV(BCLK_DIV)
    ) u_sclk (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .en        (i_en),
        .sclk      (o_sclk),
        .rise_tick (),
        .fall_tick (fall_tick)
    );

    // An empty FIFO at frame start sends silence.
    always_comb begin
        sample = '0;
        if (!i_empty) begin
            sample = i_rd_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            pos      <= POS_LAST;
            shift    <= '0;
            lrclk    <= CH_LEFT;
            rd_en    <= 1'b0;
            underrun <= 1'b0;
        end else if (!i_en) begin
            pos      <= POS_LAST;
            shift    <= '0;
            lrclk    <= CH_LEFT;
            rd_en    <= 1'b0;
            underrun <= 1'b0;
        end else begin
            rd_en    <= 1'b0;
            underrun <= 1'b0;
            if (fall_tick) begin
                pos   <= pos + 5'd1;
                lrclk <= lr_for_pos(pos + 5'd1);
                if (pos == POS_LAST) begin
                    shift    <= {sample, sample};
                    rd_en    <= !i_empty;
                    underrun <= i_empty;
                end else begin
                    shift <= shift << 1;
                end
            end
        end
    end

    assign o_sdata    = shift[2*DATA_BIT-1];
    assign o_lrclk    = lrclk;
    assign o_rd_en    = rd_en;
    assign o_underrun = underrun;

endmodule

// File: tb/tb_i2s_tx_stream.sv
// Scoreboard bench: stimulus queues expected frames, a monitor
// rebuilds each 32-bit frame from SDATA on SCLK rising edges.
module tb_i2s_tx_stream;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        empty;
    logic [15:0] rd_data;
    logic        rd_en, sclk, lrclk, sdata, underrun;

    logic        en4;
    logic        empty4;
    logic [15:0] rd_data4;
    logic        rd_en4, sclk4, lrclk4, sdata4, underrun4;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        und;
        logic [15:0] v;
    } exp_t;

    exp_t        expq[$];
    logic [15:0] fifo[$];

    always #5 clk = ~clk;

    i2s_tx_stream #(.BCLK_DIV(2)) dut (
        .i_clk      (clk),
        .i_reset_n  (rst_n),
        .i_en       (en),
        .i_empty    (empty),
        .i_rd_data  (rd_data),
        .o_rd_en    (rd_en),
        .o_sclk     (sclk),
        .o_lrclk    (lrclk),
        .o_sdata    (sdata),
        .o_underrun (underrun)
    );

    i2s_tx_stream #(.BCLK_DIV(4)) dut4 (
        .i_clk      (clk),
        .i_reset_n  (rst_n),
        .i_en       (en4),
        .i_empty    (empty4),
        .i_rd_data  (rd_data4),
        .o_rd_en    (rd_en4),
        .o_sclk     (sclk4),
        .o_lrclk    (lrclk4),
        .o_sdata    (sdata4),
        .o_underrun (underrun4)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", nm, act, req);
        end
    endtask

    function automatic void fifo_sync();
        empty   = (fifo.size() == 0);
        rd_data = empty ? 16'h0 : fifo[0];
    endfunction

    task automatic push_fifo(input logic [15:0] v);
        fifo.push_back(v);
        fifo_sync();
    endtask

    // FIFO model: the pop strobe removes the head word.
    always begin
        @(posedge clk);
        #1;
        if (rd_en && fifo.size() > 0) begin
            void'(fifo.pop_front());
            fifo_sync();
        end
    end

    task automatic wait_pulse(input int bound, input bit sel_u,
                              output int n);
        n = -1;
        for (int i = 1; i <= bound; i++) begin
            @(posedge clk);
            #1;
            if ((sel_u ? underrun : rd_en) === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    logic        act = 1'b0;
    logic        psclk = 1'b0;
    logic [31:0] sh;
    int          nb;
    int          lrbad;
    logic        f_und, f_rd;
    exp_t        e;

    always @(negedge clk) begin
        if (!rst_n || !en) begin
            act = 1'b0;
        end else begin
            if (rd_en || underrun) begin
                act   = 1'b1;
                nb    = 0;
                sh    = '0;
                lrbad = 0;
                f_und = underrun;
                f_rd  = rd_en;
            end
            if (act && sclk && !psclk) begin
                sh = {sh[30:0], sdata};
                if (lrclk !== (nb >= 15 && nb <= 30)) lrbad++;
                nb++;
                if (nb == 32) begin
                    act = 1'b0;
                    if (expq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL frame_unexpected: got %0h want none", sh);
                    end else begin
                        e = expq.pop_front();
                        chk("frame_data", sh, {e.v, e.v});
                        chk("frame_flags", {30'b0, f_rd, f_und},
                            {30'b0, !e.und, e.und});
                        chk("frame_lrclk", lrbad, 0);
                    end
                end
            end
        end
        psclk = sclk;
    end

    initial begin
        int n;
        int pops;
        rst_n    = 1'b0;
        en       = 1'b0;
        en4      = 1'b0;
        empty4   = 1'b0;
        rd_data4 = 16'h1234;
        fifo_sync();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out", {27'b0, sclk, lrclk, sdata, rd_en, underrun}, 0);
        chk("reset_out4", {27'b0, sclk4, lrclk4, sdata4, rd_en4, underrun4}, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // basic frame
        push_fifo(16'hA5C3);
        expq.push_back({1'b0, 16'hA5C3});
        en = 1'b1;
        wait_pulse(20, 1'b0, n);
        chk("first_pop_latency", n, 4);

        // underrun, then mid-frame refill
        expq.push_back({1'b1, 16'h0});
        wait_pulse(200, 1'b1, n);
        chk("underrun_interval", n, 128);
        chk("no_pop_on_underrun", {31'b0, rd_en}, 0);
        @(posedge clk);
        #1;
        chk("underrun_one_cycle", {31'b0, underrun}, 0);
        repeat (38) @(posedge clk);
        #1;
        push_fifo(16'h7FFF);
        expq.push_back({1'b0, 16'h7FFF});
        for (int i = 1; i <= 4; i++) push_fifo(16'(i));
        for (int i = 1; i <= 3; i++) expq.push_back({1'b0, 16'(i)});
        wait_pulse(200, 1'b0, n);
        chk("pop_after_underrun", n, 89);
        for (int i = 1; i <= 4; i++) begin
            wait_pulse(200, 1'b0, n);
            chk("pop_interval", n, 128);
        end

        // reset during k=20 of the frame carrying 4
        repeat (81) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("reset_mid_frame", {27'b0, sclk, lrclk, sdata, rd_en, underrun}, 0);
        repeat (3) @(posedge clk);
        #1;
        push_fifo(16'h0005);
        rst_n = 1'b1;
        wait_pulse(20, 1'b0, n);
        chk("pop_after_reset", n, 4);

        // enable drop at k=7 of the frame carrying 5
        repeat (28) @(posedge clk);
        #1;
        en = 1'b0;
        @(posedge clk);
        #1;
        chk("en_drop_out", {27'b0, sclk, lrclk, sdata, rd_en, underrun}, 0);
        pops = 0;
        push_fifo(16'h0006);
        expq.push_back({1'b0, 16'h0006});
        repeat (9) begin
            @(posedge clk);
            #1;
            if (rd_en || underrun) pops++;
        end
        chk("no_pop_while_off", pops, 0);
        en = 1'b1;
        wait_pulse(20, 1'b0, n);
        chk("pop_after_reenable", n, 4);
        expq.push_back({1'b1, 16'h0});
        wait_pulse(200, 1'b1, n);
        chk("underrun_after_6", n, 128);
        repeat (127) @(posedge clk);
        #1;
        en = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("sb_drained", expq.size(), 0);

        // BCLK_DIV=4 instance
        begin
            int t, last_rise, last_fall, last_pop;
            int dbad, lrbad4, nedge, nlr, und4;
            logic ps, pl;
            t = 0; last_rise = -1; last_fall = -1; last_pop = -1;
            dbad = 0; lrbad4 = 0; nedge = 0; nlr = 0; und4 = 0;
            en4 = 1'b1;
            n = -1;
            for (int i = 1; i <= 40; i++) begin
                @(posedge clk);
                #1;
                if (rd_en4) begin
                    n = i;
                    break;
                end
            end
            chk("first_pop_latency4", n, 8);
            last_pop = 0;
            ps = sclk4;
            pl = lrclk4;
            repeat (700) begin
                @(posedge clk);
                #1;
                t++;
                if (sclk4 && !ps) begin
                    nedge++;
                    if (last_fall >= 0 && t - last_fall != 4) dbad++;
                    last_rise = t;
                end
                if (!sclk4 && ps) begin
                    nedge++;
                    if (last_rise >= 0 && t - last_rise != 4) dbad++;
                    last_fall = t;
                end
                if (lrclk4 != pl) begin
                    nlr++;
                    if (!(ps && !sclk4)) lrbad4++;
                end
                if (underrun4) und4++;
                if (rd_en4) begin
                    chk("pop_interval4", t - last_pop, 256);
                    last_pop = t;
                end
                ps = sclk4;
                pl = lrclk4;
            end
            chk("sclk_duty4", dbad, 0);
            chk("sclk_edges4", nedge, 175);
            chk("lrclk_on_fall4", lrbad4, 0);
            chk("lrclk_toggles4", {31'b0, nlr >= 4}, 1);
            chk("no_underrun4", und4, 0);
            en4 = 1'b0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
